// File: rtl/ram_mirror_dma_pkg.sv
// rtl/ram_mirror_dma_pkg.sv - shared FSM encoding and default address map for ram_mirror_dma
package ram_mirror_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_XFER = 2'd2
  } dma_state_t;

  localparam int unsigned DEF_RAM_END = 32'h2000;
  localparam int unsigned DEF_DMA_REG = 32'h4014;

  // Index width for a burst length; a 1-word burst still needs a 1-bit index.
  function automatic int idx_width(input int len);
    return (len <= 1) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/ram_mirror_dma_if.sv
// rtl/ram_mirror_dma_if.sv - DMA output stream: word, destination index, valid/ready handshake
interface ram_mirror_dma_if #(
  parameter int IDX_W  = 8,
  parameter int DATA_W = 8
);
  logic [IDX_W-1:0]  dma_addr;
  logic [DATA_W-1:0] dma_data;
  logic              dma_valid;
  logic              dma_ready;

  modport master (output dma_addr, output dma_data, output dma_valid, input dma_ready);
  modport slave  (input dma_addr, input dma_data, input dma_valid, output dma_ready);
endinterface

// File: rtl/ram_mirror_dma_ram_sp_core.sv
// rtl/ram_mirror_dma_ram_sp_core.sv - single-port synchronous RAM with a resettable read register
module ram_sp_core #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Array contents deliberately survive reset; only the read register clears.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) begin
      rdata_d = mem[addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/ram_mirror_dma.sv
// rtl/ram_mirror_dma.sv - mirrored CPU RAM with a page-copy DMA engine that stalls the CPU
module ram_mirror_dma
  import ram_mirror_dma_pkg::*;
#(
  parameter int          ADDR_W  = 16,
  parameter int          DATA_W  = 8,
  parameter int          DEPTH_W = 11,
  parameter int unsigned RAM_END = DEF_RAM_END,
  parameter int unsigned DMA_REG = DEF_DMA_REG,
  parameter int          DMA_LEN = 256,
  localparam int         IDX_W   = idx_width(DMA_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data,
  input  logic              rw_n,
  input  logic              cs_n,
  output logic              cpu_rdy,
  ram_mirror_dma_if.master  dma
);
  dma_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] page_q, page_d;
  logic              valid_q, valid_d;
  logic              rdy_q, rdy_d;

  logic               in_win, is_trig, idle;
  logic               cpu_rd, cpu_wr, trig;
  logic               ram_en;
  logic [DEPTH_W-1:0] ram_addr;
  logic [DATA_W-1:0]  ram_rdata;

  assign in_win  = (32'(addr) < RAM_END);
  assign is_trig = (32'(addr) == DMA_REG);
  assign idle    = (state_q == ST_IDLE);
  assign cpu_rd  = idle && !cs_n && rw_n && in_win;
  assign cpu_wr  = idle && !cs_n && !rw_n && in_win && !is_trig;
  assign trig    = idle && !cs_n && !rw_n && is_trig;

  // The RAM port belongs to the DMA only in RD; the source wraps into the physical array.
  assign ram_en   = cpu_rd || cpu_wr || (state_q == ST_RD);
  assign ram_addr = (state_q == ST_RD) ? DEPTH_W'({page_q, idx_q}) : addr[DEPTH_W-1:0];

  ram_sp_core #(
    .ADDR_W (DEPTH_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ram_en),
    .we    (cpu_wr),
    .addr  (ram_addr),
    .wdata (data),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    page_d  = page_q;
    valid_d = valid_q;
    rdy_d   = rdy_q;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          page_d  = data;
          idx_d   = '0;
          rdy_d   = 1'b0;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        valid_d = 1'b1;
        state_d = ST_XFER;
      end
      ST_XFER: begin
        if (dma.dma_ready) begin
          valid_d = 1'b0;
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_W'(DMA_LEN - 1)) begin
            rdy_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        rdy_d   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      page_q  <= '0;
      valid_q <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      page_q  <= page_d;
      valid_q <= valid_d;
      rdy_q   <= rdy_d;
    end
  end

  // The RAM read register doubles as the DMA word; it is frozen while in XFER.
  assign data          = cpu_rd ? ram_rdata : {DATA_W{1'bz}};
  assign cpu_rdy       = rdy_q;
  assign dma.dma_addr  = idx_q;
  assign dma.dma_data  = ram_rdata;
  assign dma.dma_valid = valid_q;
endmodule

// File: tb/tb_ram_mirror_dma.sv
// tb/tb_ram_mirror_dma.sv - self-checking bench for ram_mirror_dma
module tb_ram_mirror_dma;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        rw_n = 1'b1;
  logic        cs_n = 1'b1;
  logic        cpu_rdy;
  tri1  [7:0]  data_bus;
  logic [7:0]  tb_dout = 8'h00;
  logic        tb_oe = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [7:0] ref_mem [2048];
  bit         ref_ok  [2048];

  assign data_bus = tb_oe ? tb_dout : 8'bz;

  ram_mirror_dma_if #(.IDX_W(8), .DATA_W(8)) dma_if ();

  ram_mirror_dma #(
    .ADDR_W  (16),
    .DATA_W  (8),
    .DEPTH_W (11),
    .RAM_END (32'h2000),
    .DMA_REG (32'h4014),
    .DMA_LEN (256)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .data    (data_bus),
    .rw_n    (rw_n),
    .cs_n    (cs_n),
    .cpu_rdy (cpu_rdy),
    .dma     (dma_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; rw_n = 1'b0; cs_n = 1'b0; tb_dout = d; tb_oe = 1'b1;
    @(negedge clk);
    cs_n = 1'b1; rw_n = 1'b1; tb_oe = 1'b0;
    if (a < 16'h2000) begin
      ref_mem[a[10:0]] = d;
      ref_ok[a[10:0]]  = 1'b1;
    end
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; rw_n = 1'b1; cs_n = 1'b0; tb_oe = 1'b0;
    @(negedge clk);
    d = data_bus;
    cs_n = 1'b1;
  endtask

  // Undriven bus reads as FF through the pull-up.
  function automatic logic [7:0] model_read(input logic [15:0] a);
    return (a < 16'h2000) ? ref_mem[a[10:0]] : 8'hFF;
  endfunction

  // mode 0: always ready, 1: two-low/two-high pattern, 2: random.
  task automatic run_burst(input logic [7:0] page, input int mode, input bit lockout,
                           input int rst_at, output bit aborted);
    logic [7:0] exp_q[$];
    int   hs, cyc;
    bit   rdy_ok, stable_ok, prev_stall, rdy;
    logic [7:0] prev_data, prev_addr;
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(ref_mem[11'((int'(page) * 256 + i) % 2048)]);
    end
    @(negedge clk);
    addr = 16'h4014; rw_n = 1'b0; cs_n = 1'b0; tb_dout = page; tb_oe = 1'b1;
    @(negedge clk);
    cs_n = 1'b1; rw_n = 1'b1; tb_oe = 1'b0;
    hs = 0; cyc = 0; rdy_ok = 1'b1; stable_ok = 1'b1; prev_stall = 1'b0; aborted = 1'b0;
    prev_data = 8'h00; prev_addr = 8'h00;
    while (hs < 256 && cyc < 4000) begin
      if (lockout) begin
        if (cyc == 10) begin
          addr = 16'h0010; rw_n = 1'b0; cs_n = 1'b0; tb_dout = 8'h77; tb_oe = 1'b1;
        end else if (cyc == 11) begin
          addr = 16'h4014; tb_dout = 8'h05;
        end else if (cyc == 12) begin
          addr = 16'h0010; rw_n = 1'b1; tb_oe = 1'b0;
        end else if (cyc == 13) begin
          check("lock_bus_hiz", data_bus, 8'hFF);
          cs_n = 1'b1;
        end
      end
      if (rst_at >= 0 && hs == rst_at && dma_if.dma_valid === 1'b1) begin
        check("pre_rst_idx", dma_if.dma_addr, 32'(rst_at));
        rst_n = 1'b0;
        #1;
        check("rst_valid", dma_if.dma_valid, 0);
        check("rst_cpu_rdy", cpu_rdy, 1);
        check("rst_dma_addr", dma_if.dma_addr, 0);
        check("rst_dma_data", dma_if.dma_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dma_if.dma_ready = 1'b0;
        aborted = 1'b1;
        return;
      end
      if (cpu_rdy !== 1'b0) rdy_ok = 1'b0;
      if (prev_stall && (dma_if.dma_valid !== 1'b1 || dma_if.dma_data !== prev_data ||
                         dma_if.dma_addr !== prev_addr)) stable_ok = 1'b0;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = cyc[1];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      dma_if.dma_ready = rdy;
      if (dma_if.dma_valid === 1'b1) begin
        if (rdy) begin
          check("word_data", dma_if.dma_data, exp_q[hs]);
          check("word_idx", dma_if.dma_addr, 32'(hs[7:0]));
          hs++;
        end
        prev_stall = !rdy;
        prev_data  = dma_if.dma_data;
        prev_addr  = dma_if.dma_addr;
      end else begin
        prev_stall = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    dma_if.dma_ready = 1'b0;
    check("burst_words", hs, 256);
    check("cpu_rdy_low_during_burst", rdy_ok, 1);
    check("stall_stable", stable_ok, 1);
    check("cpu_rdy_after_burst", cpu_rdy, 1);
    check("valid_after_burst", dma_if.dma_valid, 0);
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  exp;
  } vec_t;

  initial begin
    vec_t       vecs[$];
    logic [7:0] rb;
    logic [15:0] a;
    bit         ab;
    bit         quiet;

    dma_if.dma_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_cpu_rdy", cpu_rdy, 1);
    check("reset_valid", dma_if.dma_valid, 0);
    check("reset_dma_addr", dma_if.dma_addr, 0);
    check("reset_dma_data", dma_if.dma_data, 0);
    check("reset_bus_hiz", data_bus, 8'hFF);
    rst_n = 1'b1;

    vecs.push_back('{1'b1, 16'h0005, 8'hA5, 8'h00});
    vecs.push_back('{1'b0, 16'h0805, 8'h00, 8'hA5});
    vecs.push_back('{1'b0, 16'h1805, 8'h00, 8'hA5});
    vecs.push_back('{1'b1, 16'h2005, 8'h11, 8'h00});
    vecs.push_back('{1'b0, 16'h2005, 8'h00, 8'hFF});
    vecs.push_back('{1'b0, 16'h0005, 8'h00, 8'hA5});
    vecs.push_back('{1'b1, 16'h07FF, 8'h3C, 8'h00});
    vecs.push_back('{1'b0, 16'h0FFF, 8'h00, 8'h3C});
    vecs.push_back('{1'b0, 16'h1FFF, 8'h00, 8'h3C});
    vecs.push_back('{1'b0, 16'h27FF, 8'h00, 8'hFF});
    vecs.push_back('{1'b1, 16'h1000, 8'h5A, 8'h00});
    vecs.push_back('{1'b0, 16'h0000, 8'h00, 8'h5A});
    vecs.push_back('{1'b0, 16'hFFFF, 8'h00, 8'hFF});
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) begin
        cpu_write(vecs[i].a, vecs[i].d);
      end else begin
        cpu_read(vecs[i].a, rb);
        check($sformatf("vec%0d_read_%04h", i, vecs[i].a), rb, vecs[i].exp);
      end
    end

    for (int n = 0; n < 300; n++) begin
      a = 16'($urandom_range(0, 5) * 2048 + $urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        cpu_write(a, 8'($urandom));
      end else begin
        cpu_read(a, rb);
        if (a >= 16'h2000) check("rnd_hiz", rb, 8'hFF);
        else if (ref_ok[a[10:0]]) check("rnd_read", rb, model_read(a));
      end
    end

    for (int i = 0; i < 256; i++) cpu_write(16'h0200 + 16'(i), 8'(i));

    run_burst(8'h02, 0, 1'b0, -1, ab);
    run_burst(8'h0A, 1, 1'b0, -1, ab);

    cpu_write(16'h0010, 8'h42);
    run_burst(8'h02, 0, 1'b1, -1, ab);
    cpu_read(16'h0010, rb);
    check("lockout_write_dropped", rb, 8'h42);
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (dma_if.dma_valid !== 1'b0 || cpu_rdy !== 1'b1) quiet = 1'b0;
    end
    check("no_second_burst", quiet, 1);

    run_burst(8'h02, 0, 1'b0, 100, ab);
    check("reset_point_reached", ab, 1);
    cpu_read(16'h0264, rb);
    check("mem_after_reset_0264", rb, model_read(16'h0264));
    cpu_read(16'h0010, rb);
    check("mem_after_reset_0010", rb, model_read(16'h0010));
    cpu_read(16'h07FF, rb);
    check("mem_after_reset_07ff", rb, model_read(16'h07FF));
    run_burst(8'h02, 2, 1'b0, -1, ab);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
